// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator.
// Holds the 640x480@60 default geometry, the default counter width and the
// derived line/frame totals. There are no ports; modules import these values.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_CNT_W    = 13;

  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis (horizontal or vertical): a wrapping position counter plus
// combinational decode of the sync pulse and the visible region.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   inc         - advance the counter by one position this clk
//   count       - current position, 0..TOTAL-1
//   wrap        - 1 when this clk's advance takes count from TOTAL-1 back to 0
//   sync_n      - sync at pin level: POL inside the sync window, ~POL outside
//   in_active   - 1 while count is inside the visible region
module vga_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  parameter int CNT_W  = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync_n,
  output logic             in_active
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

  assign wrap      = inc && (count == LAST);
  assign in_active = (count < ACT_END);
  assign sync_n    = ((count >= SYNC_START) && (count < SYNC_END)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Two axis counters (hc/vc) run in lock-step; one registered output stage,
// loaded only on pix_ce clks, presents coordinates, syncs and strobes aligned.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   pix_ce       - pixel enable; all state advances only when high
//   hcount       - pixel index within line
//   vcount       - line index within frame
//   hsync, vsync - sync outputs at pin level (asserted level per HS_POL/VS_POL)
//   active       - visible-region flag
//   line_start   - 1-clk pulse when the output stage loads hcount=0
//   frame_start  - 1-clk pulse when the output stage loads (0,0)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CNT_W < 1) begin : g_bad_width
    $error("vga_timing_gen: every timing width and CNT_W must be >= 1");
  end
  if ((64'd1 << CNT_W) < 64'(H_TOTAL) || (64'd1 << CNT_W) < 64'(V_TOTAL)) begin : g_bad_cnt_w
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic [CNT_W-1:0] hc, vc;
  logic             h_wrap, v_wrap;
  logic             h_sync_lvl, v_sync_lvl;
  logic             h_act, v_act;
  logic             at_origin;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(HS_POL), .CNT_W(CNT_W)
  ) u_h (
    .clk(clk), .rst(rst), .inc(pix_ce),
    .count(hc), .wrap(h_wrap), .sync_n(h_sync_lvl), .in_active(h_act)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(VS_POL), .CNT_W(CNT_W)
  ) u_v (
    .clk(clk), .rst(rst), .inc(pix_ce & h_wrap),
    .count(vc), .wrap(v_wrap), .sync_n(v_sync_lvl), .in_active(v_act)
  );

  // Tracks "hc/vc currently sit at (0,0)": set by reset or by a frame wrap,
  // cleared by any other advance. Saves a full-width compare on both axes.
  always_ff @(posedge clk) begin
    if (rst) begin
      at_origin <= 1'b1;
    end else if (pix_ce) begin
      at_origin <= v_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Strobes are single-clk: cleared on every clk, including pix_ce=0 ones.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        hcount      <= hc;
        vcount      <= vc;
        hsync       <= h_sync_lvl;
        vsync       <= v_sync_lvl;
        active      <= h_act & v_act;
        line_start  <= (hc == '0);
        frame_start <= at_origin;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // ---------------- default 640x480 instance ----------------
  logic        rst_d = 1'b1, ce_d = 1'b0;
  logic [12:0] d_hcount, d_vcount;
  logic        d_hsync, d_vsync, d_active, d_ls, d_fs;

  vga_timing_gen u_dut_d (
    .clk(clk), .rst(rst_d), .pix_ce(ce_d),
    .hcount(d_hcount), .vcount(d_vcount), .hsync(d_hsync), .vsync(d_vsync),
    .active(d_active), .line_start(d_ls), .frame_start(d_fs)
  );

  // ---------------- small 7x6 instance, positive syncs ----------------
  logic       rst_s = 1'b1, ce_s = 1'b0;
  logic [3:0] s_hcount, s_vcount;
  logic       s_hsync, s_vsync, s_active, s_ls, s_fs;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)
  ) u_dut_s (
    .clk(clk), .rst(rst_s), .pix_ce(ce_s),
    .hcount(s_hcount), .vcount(s_vcount), .hsync(s_hsync), .vsync(s_vsync),
    .active(s_active), .line_start(s_ls), .frame_start(s_fs)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference state: *_i = next coordinate to be presented, e_* = expected outputs.
  int d_hi = 0, d_vi = 0;
  int e_dh = 0, e_dv = 0, e_dhs = 1, e_dvs = 1, e_dact = 0, e_dls = 0, e_dfs = 0;
  int s_hi = 0, s_vi = 0;
  int e_sh = 0, e_sv = 0, e_shs = 0, e_svs = 0, e_sact = 0, e_sls = 0, e_sfs = 0;

  task automatic step_d(input logic ce);
    ce_d = ce;
    @(posedge clk); #1;
    if (rst_d) begin
      d_hi = 0; d_vi = 0; e_dh = 0; e_dv = 0; e_dhs = 1; e_dvs = 1;
      e_dact = 0; e_dls = 0; e_dfs = 0;
    end else if (ce) begin
      e_dh = d_hi; e_dv = d_vi;
      e_dhs = (d_hi >= 656 && d_hi <= 751) ? 0 : 1;
      e_dvs = (d_vi >= 490 && d_vi <= 491) ? 0 : 1;
      e_dact = (d_hi < 640 && d_vi < 480) ? 1 : 0;
      e_dls = (d_hi == 0) ? 1 : 0;
      e_dfs = (d_hi == 0 && d_vi == 0) ? 1 : 0;
      if (d_hi == 799) begin
        d_hi = 0;
        d_vi = (d_vi == 524) ? 0 : d_vi + 1;
      end else begin
        d_hi = d_hi + 1;
      end
    end else begin
      e_dls = 0; e_dfs = 0;
    end
    chk("d_hcount", 32'(d_hcount), 32'(e_dh));
    chk("d_vcount", 32'(d_vcount), 32'(e_dv));
    chk("d_hsync",  32'(d_hsync),  32'(e_dhs));
    chk("d_vsync",  32'(d_vsync),  32'(e_dvs));
    chk("d_active", 32'(d_active), 32'(e_dact));
    chk("d_line_start",  32'(d_ls), 32'(e_dls));
    chk("d_frame_start", 32'(d_fs), 32'(e_dfs));
  endtask

  task automatic step_s(input logic ce);
    ce_s = ce;
    @(posedge clk); #1;
    if (rst_s) begin
      s_hi = 0; s_vi = 0; e_sh = 0; e_sv = 0; e_shs = 0; e_svs = 0;
      e_sact = 0; e_sls = 0; e_sfs = 0;
    end else if (ce) begin
      e_sh = s_hi; e_sv = s_vi;
      e_shs = (s_hi == 5) ? 1 : 0;
      e_svs = (s_vi == 4) ? 1 : 0;
      e_sact = (s_hi < 4 && s_vi < 3) ? 1 : 0;
      e_sls = (s_hi == 0) ? 1 : 0;
      e_sfs = (s_hi == 0 && s_vi == 0) ? 1 : 0;
      if (s_hi == 6) begin
        s_hi = 0;
        s_vi = (s_vi == 5) ? 0 : s_vi + 1;
      end else begin
        s_hi = s_hi + 1;
      end
    end else begin
      e_sls = 0; e_sfs = 0;
    end
    chk("s_hcount", 32'(s_hcount), 32'(e_sh));
    chk("s_vcount", 32'(s_vcount), 32'(e_sv));
    chk("s_hsync",  32'(s_hsync),  32'(e_shs));
    chk("s_vsync",  32'(s_vsync),  32'(e_svs));
    chk("s_active", 32'(s_active), 32'(e_sact));
    chk("s_line_start",  32'(s_ls), 32'(e_sls));
    chk("s_frame_start", 32'(s_fs), 32'(e_sfs));
  endtask

  initial begin
    int last_ls, last_fs, hs_low, vs_hi, hs_hi, fs_seen, bound;

    // ---- default: reset with pix_ce=1 for 3 clks ----
    rst_d = 1'b1;
    repeat (3) step_d(1'b1);
    rst_d = 1'b0;
    step_d(1'b1);
    chk("d_first_load_fs", 32'(d_fs), 32'd1);
    chk("d_first_load_act", 32'(d_active), 32'd1);

    // ---- default: two full lines, continuous enable ----
    last_ls = cyc; hs_low = 0;
    for (int i = 0; i < 1600; i++) begin
      step_d(1'b1);
      if (d_hsync == 1'b0) hs_low++;
      if (d_ls) begin
        chk("d_line_period", 32'(cyc - last_ls), 32'd800);
        last_ls = cyc;
      end
    end
    chk("d_hsync_low_2lines", 32'(hs_low), 32'd192);
    chk("d_after_2lines_v", 32'(d_vcount), 32'd2);

    // ---- default: mid-frame reset at (300,2) ----
    bound = 0;
    while (!(d_hcount == 13'd300 && d_vcount == 13'd2) && bound < 1000) begin
      step_d(1'b1);
      bound++;
    end
    chk("d_reach_300_timeout", 32'(bound < 1000), 32'd1);
    rst_d = 1'b1;
    step_d(1'b1);
    chk("d_midrst_hsync", 32'(d_hsync), 32'd1);
    rst_d = 1'b0;
    step_d(1'b1);
    chk("d_restart_fs", 32'(d_fs), 32'd1);

    // ---- small config: reset, then two frames continuous ----
    rst_s = 1'b1;
    repeat (3) step_s(1'b1);
    chk("s_reset_hsync", 32'(s_hsync), 32'd0);
    rst_s = 1'b0;
    last_fs = -1; fs_seen = 0; vs_hi = 0; hs_hi = 0;
    for (int i = 0; i < 84; i++) begin
      step_s(1'b1);
      if (s_vsync) vs_hi++;
      if (s_hsync) hs_hi++;
      if (s_fs) begin
        if (last_fs >= 0) chk("s_frame_period", 32'(cyc - last_fs), 32'd42);
        last_fs = cyc; fs_seen++;
      end
    end
    chk("s_frames_seen", 32'(fs_seen), 32'd2);
    chk("s_vsync_high_clks", 32'(vs_hi), 32'd14);
    chk("s_hsync_high_clks", 32'(hs_hi), 32'd12);

    // ---- small config: pix_ce alternating 1,0 ----
    last_fs = -1; fs_seen = 0;
    for (int i = 0; i < 200; i++) begin
      step_s(i[0] == 1'b0);
      if (s_fs) begin
        if (last_fs >= 0) chk("s_gated_frame_period", 32'(cyc - last_fs), 32'd84);
        last_fs = cyc; fs_seen++;
      end
    end
    chk("s_gated_frames_seen", 32'(fs_seen >= 2), 32'd1);

    // ---- small config: mid-frame reset at (3,2) ----
    bound = 0;
    while (!(s_hcount == 4'd3 && s_vcount == 4'd2) && bound < 100) begin
      step_s(1'b1);
      bound++;
    end
    chk("s_reach_3_2_timeout", 32'(bound < 100), 32'd1);
    rst_s = 1'b1;
    step_s(1'b1);
    chk("s_midrst_hcount", 32'(s_hcount), 32'd0);
    rst_s = 1'b0;
    step_s(1'b0);
    chk("s_hold_no_ce_fs", 32'(s_fs), 32'd0);
    step_s(1'b1);
    chk("s_restart_ls", 32'(s_ls), 32'd1);
    chk("s_restart_fs", 32'(s_fs), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator that replaces the fixed 800-pixel horizontal counter. It runs the horizontal and vertical counters together and decodes hsync, vsync and active-video from porch and sync widths. Sync polarity is configurable, and advance is qualified by a pixel-clock enable. Its coordinates and strobes drive the Pong renderer and the VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level (0 = active-low)
CNT_W, 13, counter width; must satisfy 2^CNT_W >= max(H_TOTAL, V_TOTAL)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pix_ce  in  1  pixel enable; state advances only on clk edges where pix_ce=1
hcount  out  CNT_W  pixel index within line, 0..H_TOTAL-1
vcount  out  CNT_W  line index within frame, 0..V_TOTAL-1
hsync  out  1  horizontal sync, level per HS_POL
vsync  out  1  vertical sync, level per VS_POL
active  out  1  1 when hcount<H_ACTIVE and vcount<V_ACTIVE
line_start  out  1  1-clk pulse when the output stage loads hcount=0
frame_start  out  1  1-clk pulse when the output stage loads hcount=0 and vcount=0

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL likewise (525).
- Internal counters hc/vc:
  - On pix_ce: hc = (hc==H_TOTAL-1) ? 0 : hc+1.
  - vc advances only when hc wraps; it wraps to 0 at V_TOTAL-1.
  - Without pix_ce, all state holds.
- Output stage: one registered stage behind hc/vc, loaded only on pix_ce cycles.
  - hcount/vcount are copies of hc/vc.
  - hsync/vsync/active are decoded from the same hc/vc, so all outputs are mutually aligned (latency 1 pix_ce-cycle).
- hsync asserted for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751 default); deasserted level is ~HS_POL.
- vsync asserted for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (490..491 default), for entire lines.
- line_start/frame_start: high for exactly one clk, namely the clk on which the output stage loads the matching coordinate. They are 0 on all other clks, including clks where pix_ce=0.
- Reset values:
  - hc=vc=0; hcount=vcount=0.
  - hsync=~HS_POL, vsync=~VS_POL.
  - active=0, line_start=0, frame_start=0.
- After rst falls, the first pix_ce loads hcount=0, vcount=0, active=1, line_start=1, frame_start=1; hc becomes 1.
- Reset mid-frame behaves identically; it takes priority over pix_ce.
- Wrap-around: the last pixel of the frame (H_TOTAL-1, V_TOTAL-1) is followed directly by (0,0), with no idle cycle.
- No arithmetic overflow: comparisons use CNT_W-bit unsigned values. Parameter constraints are checked at elaboration (all widths >= 1).

Decomposition:
- Shared package vga_timing_pkg holds:
  - default 640x480@60 constants (H_ACTIVE..V_BP);
  - CNT_W;
  - H_TOTAL/V_TOTAL as derived localparams.
- One natural sub-module: vga_axis_counter (params ACTIVE, FP, SYNC, BP, POL, CNT_W).
  - Inputs: clk, rst, inc.
  - Outputs: count, wrap, sync_n, in_active.
  - Instantiated twice: horizontal with inc=pix_ce; vertical with inc=pix_ce & h_wrap.

Test Plan:
- Reset values: rst=1 for 3 clk with pix_ce=1 -> hcount=0, vcount=0, hsync=1, vsync=1, active=0, strobes 0. First pix_ce after release -> (0,0), active=1, line_start=1, frame_start=1.
- Horizontal line, defaults, pix_ce=1: hsync=0 exactly for hcount 656..751; active=1 for hcount 0..639; line_start every 800 clks; hcount 799 followed by 0 with vcount+1.
- Full frame, defaults: frame_start period = 420000 clks; vsync=0 exactly for vcount 490..491 (1600 clks); vcount 524 wraps to 0.
- Enable gating: pix_ce toggling 1,0,1,0 -> counters advance every other clk. Strobes are 1 clk wide and never assert on pix_ce=0 clks. Frame period = 840000 clks.
- Mid-frame reset: assert rst at hcount=300, vcount=200 for 1 clk -> outputs return to reset values next clk; restart from (0,0) as in the first test.
- Small config: H=4/1/1/1, V=3/1/1/1, HS_POL=1, VS_POL=1 -> H_TOTAL=7, V_TOTAL=6; hsync=1 only at hcount=5; vsync=1 only on vcount=4; frame period 42 clks.
